// File: rtl/awgn_pkg.sv
// Shared AWGN-chain types: URNG word width and the (u0,u1) Box-Muller sample pair.
package awgn_pkg;
  localparam int URNG_W = 32;
  localparam int U0_W   = 48;
  localparam int U1_W   = 16;

  typedef struct packed {
    logic [U0_W-1:0] u0;
    logic [U1_W-1:0] u1;
  } pair_t;

  // Two consecutive words A,B form {u0,u1} = {A, B} bit-for-bit.
  function automatic pair_t make_pair(input logic [URNG_W-1:0] a,
                                      input logic [URNG_W-1:0] b);
    return pair_t'({a, b});
  endfunction
endpackage

// File: rtl/urng_pair_fifo.sv
// First-word-fall-through sync FIFO of pair_t with an explicit occupancy level.
module urng_pair_fifo
  import awgn_pkg::*;
#(
  parameter int DEPTH = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   push_i,
  input  pair_t                  data_i,
  input  logic                   pop_i,
  output pair_t                  head_o,
  output logic [$clog2(DEPTH):0] level_o
);
  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  pair_t            mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0] level_q, level_d;

  // Pointers wrap for free because DEPTH is a power of two.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (push_i) wr_ptr_d = wr_ptr_q + 1'b1;
    if (pop_i)  rd_ptr_d = rd_ptr_q + 1'b1;
    case ({push_i, pop_i})
      2'b10:   level_d = level_q + LVL_W'(1);
      2'b01:   level_d = level_q - LVL_W'(1);
      default: level_d = level_q;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      level_q  <= level_d;
    end
  end

  always_ff @(posedge clock) begin
    if (push_i) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign level_o = level_q;
endmodule

// File: rtl/urng_pair_packer.sv
// Packs consecutive URNG words into (u0,u1) pairs, buffers them, counts drops on overflow.
// Optional build macro ZERO_GUARD_EN replaces an all-zero u0 with 1 before storage.
module urng_pair_packer
  import awgn_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DROP_W = 16
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic [URNG_W-1:0]      rand_in,
  input  logic                   rand_valid,
  output logic [U0_W-1:0]        u0_out,
  output logic [U1_W-1:0]        u1_out,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] fifo_level,
  output logic [DROP_W-1:0]      drop_count
);
  localparam int          LVL_W    = $clog2(DEPTH) + 1;
  localparam logic [0:0]  ST_EMPTY = 1'b0;
  localparam logic [0:0]  ST_HALF  = 1'b1;

  function automatic logic [DROP_W-1:0] sat_inc(input logic [DROP_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  function automatic pair_t zero_guard(input pair_t p);
    pair_t g;
    g = p;
`ifdef ZERO_GUARD_EN
    if (g.u0 == '0) g.u0 = U0_W'(1);
`endif
    return g;
  endfunction

  logic [0:0]        state_q, state_d;
  logic [URNG_W-1:0] word_a_q, word_a_d;
  logic [DROP_W-1:0] drop_q, drop_d;
  logic [LVL_W-1:0]  level;
  pair_t             head;
  pair_t             pair_new;
  logic              pair_done, pop, push;

  assign out_valid = (level != '0);
  assign pop       = out_valid && out_ready;
  assign pair_done = (state_q == ST_HALF) && rand_valid;
  assign pair_new  = zero_guard(make_pair(word_a_q, rand_in));
  // A full FIFO still accepts the pair when the head leaves in the same cycle.
  assign push      = pair_done && ((level != LVL_W'(DEPTH)) || pop);

  always_comb begin
    state_d  = state_q;
    word_a_d = word_a_q;
    drop_d   = drop_q;
    if (rand_valid) begin
      if (state_q == ST_EMPTY) begin
        state_d  = ST_HALF;
        word_a_d = rand_in;
      end else begin
        state_d = ST_EMPTY;
      end
    end
    if (pair_done && !push) drop_d = sat_inc(drop_q);
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= ST_EMPTY;
      drop_q  <= '0;
    end else begin
      state_q <= state_d;
      drop_q  <= drop_d;
    end
  end

  always_ff @(posedge clock) begin
    word_a_q <= word_a_d;
  end

  urng_pair_fifo #(
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset   (reset),
    .push_i  (push),
    .data_i  (pair_new),
    .pop_i   (pop),
    .head_o  (head),
    .level_o (level)
  );

  assign u0_out     = out_valid ? head.u0 : '0;
  assign u1_out     = out_valid ? head.u1 : '0;
  assign fifo_level = level;
  assign drop_count = drop_q;
endmodule
